// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, FETCH/WAIT memory handshake and IF/ID pipeline register.
// One-clock fetch-to-decode latency; stalls on PCWrite/IFID_Write or imem_ready=0, and a taken branch flushes IF/ID.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        PCWrite,
  input  logic        IFID_Write,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_instr,
  input  logic        imem_ready,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid,
  output logic [15:0] fetch_count
);

  typedef enum logic {FETCH = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] redirectPc;

  assign imem_addr  = pc;
  assign imem_rd    = reset;
  assign pcPlus4    = pc + 32'd4;
  assign redirectPc = branch_target & 32'hFFFF_FFFC;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      IFID_PC4    <= 32'h0;
      IFID_Instr  <= 32'h0;
      IFID_Valid  <= 1'b0;
      fetch_count <= 16'h0;
      state       <= FETCH;
    end else if (PCSrc) begin
      pc         <= redirectPc;
      IFID_PC4   <= 32'h0;
      IFID_Instr <= 32'h0;
      IFID_Valid <= 1'b0;
      state      <= FETCH;
    end else begin
      case (state)
        FETCH:   if (!imem_ready) state <= WAIT;
        default: if (imem_ready)  state <= FETCH;
      endcase

      // A stall or a missing instruction both keep the PC; IF/ID then takes a bubble only if allowed to write.
      if (!PCWrite || !imem_ready) begin
        if (IFID_Write) begin
          IFID_PC4   <= 32'h0;
          IFID_Instr <= 32'h0;
          IFID_Valid <= 1'b0;
        end
      end else if (IFID_Write) begin
        pc         <= pcPlus4;
        IFID_PC4   <= pcPlus4;
        IFID_Instr <= imem_instr;
        IFID_Valid <= 1'b1;
        if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port PCWrite, input, 1, PC write enable from the stall unit (0 = stall).
REQ-005 The block SHALL have port IFID_Write, input, 1, IF/ID register write enable from the stall unit (0 = hold).
REQ-006 The block SHALL have port PCSrc, input, 1, taken-branch redirect request.
REQ-007 The block SHALL have port branch_target, input, 32, redirect address.
REQ-008 The block SHALL have port imem_addr, output, 32, instruction memory address.
REQ-009 The block SHALL have port imem_rd, output, 1, instruction memory read request.
REQ-010 The block SHALL have port imem_instr, input, 32, instruction memory read data.
REQ-011 The block SHALL have port imem_ready, input, 1, imem_instr valid for the current imem_addr.
REQ-012 The block SHALL have port IFID_PC4, output, 32, registered PC+4 of the fetched instruction.
REQ-013 The block SHALL have port IFID_Instr, output, 32, registered instruction to the decode stage.
REQ-014 The block SHALL have port IFID_Valid, output, 1, 1 = IFID_Instr is a real instruction, 0 = bubble.
REQ-015 The block SHALL have port fetch_count, output, 16, count of instructions delivered to IF/ID.

Function
REQ-016 The block SHALL drive imem_addr combinationally from the PC register, and imem_rd SHALL be 1 in every cycle except while reset is asserted.
REQ-017 The block SHALL implement a two-state FSM, FETCH and WAIT; FETCH -> WAIT when imem_rd=1 and imem_ready=0 with no redirect; WAIT -> FETCH when imem_ready=1 or PCSrc=1.
REQ-018 The block SHALL hold imem_addr stable in WAIT until imem_ready=1 or PCSrc=1.
REQ-019 Priority 1: when PCSrc=1, the block SHALL load PC with {branch_target[31:2],2'b00}, set IFID_Instr=0, IFID_PC4=0, IFID_Valid=0, and go to FETCH, regardless of PCWrite, IFID_Write, imem_ready.
REQ-020 Priority 2: when PCSrc=0 and PCWrite=0, the block SHALL hold PC; IF/ID SHALL hold if IFID_Write=0, otherwise load a bubble (all fields 0).
REQ-021 Priority 3: when PCSrc=0, PCWrite=1 and imem_ready=0, the block SHALL hold PC; IF/ID SHALL load a bubble if IFID_Write=1, otherwise hold.
REQ-022 Priority 4: when PCSrc=0, PCWrite=1, IFID_Write=1 and imem_ready=1, the block SHALL load IF/ID with {PC+4, imem_instr, 1} and PC with PC+4 in the same edge.
REQ-023 When PCSrc=0, PCWrite=1, IFID_Write=0, the block SHALL hold both PC and IF/ID.
REQ-024 PC+4 SHALL be computed modulo 2^32; PC=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-025 fetch_count SHALL increment by 1 on every REQ-022 load and SHALL saturate at 16'hFFFF.
REQ-026 Fetch-to-decode latency SHALL be one clock: imem_instr sampled at edge N appears on IFID_Instr after edge N.

Reset
REQ-027 While reset=0, the block SHALL immediately force PC=RESET_PC, IFID_PC4=0, IFID_Instr=0, IFID_Valid=0, fetch_count=0, state=FETCH, imem_rd=0.
REQ-028 Reset asserted mid-WAIT or mid-stall SHALL discard the pending fetch; the first fetch after reset release SHALL be from RESET_PC.

Verification
REQ-029 Reset release, imem_ready=1, no stall, 3 edges -> imem_addr 0,4,8,12; IFID_PC4 4,8,12; IFID_Valid=1; fetch_count=3.
REQ-030 PCWrite=0, IFID_Write=0 for 2 cycles at PC=8 -> imem_addr stays 8, IF/ID unchanged, fetch_count unchanged.
REQ-031 imem_ready=0 for 3 cycles at PC=16 -> state WAIT, imem_addr=16, IFID_Valid=0 bubbles; ready=1 -> IFID_PC4=20, Valid=1.
REQ-032 PCSrc=1, branch_target=32'h0000_0103 during WAIT with PCWrite=0 -> next PC=32'h0000_0100, IF/ID flushed to 0, state FETCH.
REQ-033 RESET_PC=32'hFFFF_FFFC, one fetch -> PC=0, IFID_PC4=0, IFID_Valid=1; reset asserted mid-cycle -> outputs cleared without a clock edge.
